adc_decimator: RTL

- Digital post-processing stage directly downstream of the 8-bit RNM ADC.
- Takes raw ADC bit vectors at the sample rate, accumulates 2^log2_ratio samples and produces one averaged code per block, together with a saturation flag.
- Presents each result on a ready/valid output with a one-entry holding register and a sticky overrun flag for the digital back-end.
- Integer-only logic, usable unchanged under FORMAL.

---
 rtl/adc_decimator.sv | 92 +++++++++
 1 files changed

// File: rtl/adc_decimator.sv
// Block-averaging decimator for the RNM ADC: sums 2^log2_ratio samples and emits
// one truncated average per block through a one-entry ready/valid holding register.
module adc_decimator #(
  parameter int bits       = 8,
  parameter int log2_ratio = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [0:bits-1] in,
  input  logic            in_valid,
  output logic [bits-1:0] out,
  output logic            out_sat,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overrun
);

  localparam int AW = bits + log2_ratio;
  localparam int CW = (log2_ratio > 0) ? log2_ratio : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << log2_ratio) - 1);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic [bits-1:0] code;
  logic            code_sat;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   sum;
  logic [CW-1:0]   cnt;
  logic            sat_acc;
  logic            last;
  logic            complete;
  logic [bits-1:0] result;
  logic            result_sat;
  logic            state;
  logic            accept;

  // The converter presents its first (MSB) decision at the far end of the bus.
  for (genvar k = 0; k < bits; k++) begin : g_rev
    assign code[k] = in[bits-1-k];
  end

  assign code_sat   = (code == '0) || (code == '1);
  assign sum        = acc + AW'(code);
  // With log2_ratio=0 the counter is pinned at zero and every sample is a block.
  assign last       = (cnt == CNT_LAST);
  assign complete   = in_valid && last;
  assign result     = sum[AW-1:log2_ratio];
  assign result_sat = sat_acc | code_sat;
  assign accept     = (state == FULL) && out_ready;
  assign out_valid  = (state == FULL);

  // NOTE: sequential state uses non-blocking assignments and an async reset in the
  // sensitivity list, so rst clears everything without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      sat_acc <= 1'b0;
    end else if (complete) begin
      acc     <= '0;
      cnt     <= '0;
      sat_acc <= 1'b0;
    end else if (in_valid) begin
      acc     <= sum;
      cnt     <= cnt + CW'(1);
      sat_acc <= result_sat;
    end
  end

  // A completion is loaded whenever the slot is empty or is being drained this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      out     <= '0;
      out_sat <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (complete && (state == EMPTY || accept)) begin
        state   <= FULL;
        out     <= result;
        out_sat <= result_sat;
      end else if (accept) begin
        state   <= EMPTY;
      end
      if (complete && state == FULL && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
